rob_commit_unit: RTL and testbench

Reorder buffer for the out-of-order core: allocates in-order entries for dispatched instructions, captures results from the common data bus (CDB), and retires them in program order. It is the transmitting end of the commit port consumed by the register file (valid/value/rd/alias) and the source of the pipeline-wide rollback pulse. It also answers dispatcher operand look-ups by ROB id.

---
 rtl/rob_commit_unit_if.sv | 49 ++++
 rtl/rob_commit_unit.sv | 129 ++++++++++++
 tb/tb_rob_commit_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_unit_if.sv
// Reorder-buffer port bundle: allocation, CDB writeback, operand query,
// commit to the register file and rollback. The ROB side is the master modport.
interface rob_commit_unit_if #(
    parameter int ID_W = 5
) ();
    logic            alloc_valid;
    logic [4:0]      alloc_rd;
    logic            alloc_is_branch;
    logic [ID_W-1:0] alloc_id;
    logic            rob_full;

    logic            cdb_valid;
    logic [ID_W-1:0] cdb_id;
    logic [31:0]     cdb_value;
    logic            cdb_mispredict;
    logic [31:0]     cdb_target;

    logic [ID_W-1:0] qry_id;
    logic            qry_ready;
    logic [31:0]     qry_value;

    logic            commit_valid;
    logic [4:0]      commit_rd;
    logic [31:0]     commit_value;
    logic [ID_W-1:0] commit_id;

    logic            rollback_signal;
    logic [31:0]     rollback_pc;

    modport master (
        input  alloc_valid, alloc_rd, alloc_is_branch,
        output alloc_id, rob_full,
        input  cdb_valid, cdb_id, cdb_value, cdb_mispredict, cdb_target,
        input  qry_id,
        output qry_ready, qry_value,
        output commit_valid, commit_rd, commit_value, commit_id,
        output rollback_signal, rollback_pc
    );

    modport slave (
        output alloc_valid, alloc_rd, alloc_is_branch,
        input  alloc_id, rob_full,
        output cdb_valid, cdb_id, cdb_value, cdb_mispredict, cdb_target,
        output qry_id,
        input  qry_ready, qry_value,
        input  commit_valid, commit_rd, commit_value, commit_id,
        input  rollback_signal, rollback_pc
    );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order reorder buffer: allocate, capture CDB results, retire in program order,
// flush on a committed mispredict. Optional ROB_CDB_BYPASS_EN forwards CDB to queries.
module rob_commit_unit #(
    parameter int ROB_SIZE = 16,
    parameter int ID_W     = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    rob_commit_unit_if.master rob
);
    localparam int IDX_W = $clog2(ROB_SIZE);

    // Handshake: alloc_valid is accepted on an edge where rob_full is low and no
    // flush is pending; commit_valid and rollback_signal are one-cycle pulses with
    // no back-pressure, and their data fields are meaningful only while they are high.
    logic [ROB_SIZE-1:0] busy, ready, is_branch, mispredict;
    logic [4:0]          rd_q     [ROB_SIZE];
    logic [31:0]         value_q  [ROB_SIZE];
    logic [31:0]         target_q [ROB_SIZE];
    logic [IDX_W-1:0]    head, tail;
    logic [IDX_W:0]      count;
    logic                flush_pending;
    logic [31:0]         flush_pc;

    logic             do_alloc, do_commit, cdb_hit;
    logic             cdb_in_range, qry_in_range;
    logic [IDX_W-1:0] cdb_idx, qry_idx;

    assign rob.rob_full = (count == (IDX_W+1)'(ROB_SIZE));
    assign rob.alloc_id = ID_W'(tail) + ID_W'(1);

    assign cdb_in_range = (rob.cdb_id != '0) && (rob.cdb_id <= ID_W'(ROB_SIZE));
    assign qry_in_range = (rob.qry_id != '0) && (rob.qry_id <= ID_W'(ROB_SIZE));
    assign cdb_idx      = IDX_W'(rob.cdb_id - ID_W'(1));
    assign qry_idx      = IDX_W'(rob.qry_id - ID_W'(1));

    // Full is judged on the registered count, so a same-cycle retire never frees a slot.
    assign do_alloc  = rob.alloc_valid && !rob.rob_full && !flush_pending;
    assign do_commit = busy[head] && ready[head] && !flush_pending;
    assign cdb_hit   = rob.cdb_valid && cdb_in_range && busy[cdb_idx] && !flush_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy            <= '0;
            ready           <= '0;
            is_branch       <= '0;
            mispredict      <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd_q[i]     <= '0;
                value_q[i]  <= '0;
                target_q[i] <= '0;
            end
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            flush_pending   <= 1'b0;
            flush_pc        <= '0;
            rob.commit_valid    <= 1'b0;
            rob.commit_rd       <= '0;
            rob.commit_value    <= '0;
            rob.commit_id       <= '0;
            rob.rollback_signal <= 1'b0;
            rob.rollback_pc     <= '0;
        end else if (rdy) begin
            rob.commit_valid    <= 1'b0;
            rob.rollback_signal <= 1'b0;
            if (flush_pending) begin
                rob.rollback_signal <= 1'b1;
                rob.rollback_pc     <= flush_pc;
                busy          <= '0;
                ready         <= '0;
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                flush_pending <= 1'b0;
            end else begin
                if (cdb_hit) begin
                    ready[cdb_idx]      <= 1'b1;
                    value_q[cdb_idx]    <= rob.cdb_value;
                    mispredict[cdb_idx] <= rob.cdb_mispredict;
                    target_q[cdb_idx]   <= rob.cdb_target;
                end
                if (do_commit) begin
                    rob.commit_valid <= 1'b1;
                    rob.commit_rd    <= rd_q[head];
                    rob.commit_value <= value_q[head];
                    rob.commit_id    <= ID_W'(head) + ID_W'(1);
                    busy[head]       <= 1'b0;
                    head             <= head + 1'b1;
                    if (is_branch[head] && mispredict[head]) begin
                        flush_pending <= 1'b1;
                        flush_pc      <= target_q[head];
                    end
                end
                if (do_alloc) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= 1'b0;
                    rd_q[tail]       <= rob.alloc_rd;
                    is_branch[tail]  <= rob.alloc_is_branch;
                    mispredict[tail] <= 1'b0;
                    tail             <= tail + 1'b1;
                end
                case ({do_alloc, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_comb begin
        rob.qry_ready = 1'b0;
        rob.qry_value = '0;
        if (qry_in_range && busy[qry_idx]) begin
`ifdef ROB_CDB_BYPASS_EN
            if (rob.cdb_valid && (rob.cdb_id == rob.qry_id) && !flush_pending) begin
                rob.qry_ready = 1'b1;
                rob.qry_value = rob.cdb_value;
            end else
`endif
            if (ready[qry_idx]) begin
                rob.qry_ready = 1'b1;
                rob.qry_value = value_q[qry_idx];
            end
        end
    end
endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: commit/rollback pulses are checked by a
// negedge monitor against an expected queue; timing and query checks are inline.
module tb_rob_commit_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic rdy_at_edge = 1'b1;

    int total = 0;
    int bad   = 0;

    // Packet: {rollback, rd, value_or_pc, id}
    logic [42:0] exp_q[$];

    rob_commit_unit_if #(.ID_W(5)) bus ();

    rob_commit_unit #(.ROB_SIZE(16), .ID_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .rob (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rdy_at_edge <= rdy;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid     = 1'b0;
        bus.alloc_rd        = '0;
        bus.alloc_is_branch = 1'b0;
        bus.cdb_valid       = 1'b0;
        bus.cdb_id          = '0;
        bus.cdb_value       = '0;
        bus.cdb_mispredict  = 1'b0;
        bus.cdb_target      = '0;
        bus.qry_id          = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic br);
        bus.alloc_valid     = 1'b1;
        bus.alloc_rd        = rd;
        bus.alloc_is_branch = br;
        tick();
        bus.alloc_valid     = 1'b0;
        bus.alloc_is_branch = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] id, input logic [31:0] val,
                       input logic mp, input logic [31:0] tgt);
        bus.cdb_valid      = 1'b1;
        bus.cdb_id         = id;
        bus.cdb_value      = val;
        bus.cdb_mispredict = mp;
        bus.cdb_target     = tgt;
        tick();
        bus.cdb_valid      = 1'b0;
        bus.cdb_mispredict = 1'b0;
    endtask

    task automatic push_commit(input logic [4:0] rd, input logic [31:0] val, input logic [4:0] id);
        exp_q.push_back({1'b0, rd, val, id});
    endtask

    task automatic pop_check(input string name, input logic [42:0] act);
        logic [42:0] exp;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected pulse %h with empty expected queue", name, act);
        end else begin
            exp = exp_q.pop_front();
            check(name, 64'(act), 64'(exp));
        end
    endtask

    // Monitor: one pop per pulse; a held pulse under rdy low is not re-counted.
    always @(negedge clk) begin
        if (!rst && rdy_at_edge) begin
            if (bus.commit_valid && bus.rollback_signal)
                check("pulse_exclusive", 64'd1, 64'd0);
            if (bus.commit_valid)
                pop_check("commit", {1'b0, bus.commit_rd, bus.commit_value, bus.commit_id});
            if (bus.rollback_signal)
                pop_check("rollback", {1'b1, 5'd0, bus.rollback_pc, 5'd0});
        end
    end

    initial begin
        idle();
        do_reset();

        // Reset state
        check("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
        check("rst_commit_rd", 64'(bus.commit_rd), 64'd0);
        check("rst_commit_value", 64'(bus.commit_value), 64'd0);
        check("rst_commit_id", 64'(bus.commit_id), 64'd0);
        check("rst_rollback", 64'(bus.rollback_signal), 64'd0);
        check("rst_rollback_pc", 64'(bus.rollback_pc), 64'd0);
        check("rst_full", 64'(bus.rob_full), 64'd0);
        check("rst_alloc_id", 64'(bus.alloc_id), 64'd1);
        check("rst_qry_ready", 64'(bus.qry_ready), 64'd0);
        check("rst_qry_value", 64'(bus.qry_value), 64'd0);

        // Basic latency: alloc at A, CDB at A+1, commit after A+2
        alloc(5'd5, 1'b0);
        check("t1_alloc_id_next", 64'(bus.alloc_id), 64'd2);
        push_commit(5'd5, 32'hDEADBEEF, 5'd1);
        cdb(5'd1, 32'hDEADBEEF, 1'b0, 32'd0);
        check("t1_no_early_commit", 64'(bus.commit_valid), 64'd0);
        tick();
        check("t1_commit_at_a2", 64'(bus.commit_valid), 64'd1);
        tick();
        check("t1_commit_pulse_end", 64'(bus.commit_valid), 64'd0);

        // Out-of-order writeback, in-order retire on consecutive cycles
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            check("t2_alloc_id", 64'(bus.alloc_id), 64'(i));
            alloc(5'(i), 1'b0);
        end
        push_commit(5'd1, 32'h11, 5'd1);
        push_commit(5'd2, 32'h22, 5'd2);
        push_commit(5'd3, 32'h33, 5'd3);
        cdb(5'd3, 32'h33, 1'b0, 32'd0);
        cdb(5'd1, 32'h11, 1'b0, 32'd0);
        cdb(5'd2, 32'h22, 1'b0, 32'd0);
        check("t2_commit1", 64'(bus.commit_id), 64'd1);
        check("t2_commit1_v", 64'(bus.commit_valid), 64'd1);
        tick();
        check("t2_commit2", 64'(bus.commit_id), 64'd2);
        check("t2_commit2_v", 64'(bus.commit_valid), 64'd1);
        tick();
        check("t2_commit3", 64'(bus.commit_id), 64'd3);
        check("t2_commit3_v", 64'(bus.commit_valid), 64'd1);
        tick();
        check("t2_drained", 64'(bus.commit_valid), 64'd0);

        // Full, dropped allocation, retire-while-full rejection, wrap
        do_reset();
        for (int i = 0; i < 16; i++) alloc(5'(i + 1), 1'b0);
        check("t3_full", 64'(bus.rob_full), 64'd1);
        alloc(5'd20, 1'b0);
        check("t3_17th_dropped_full", 64'(bus.rob_full), 64'd1);
        check("t3_17th_dropped_id", 64'(bus.alloc_id), 64'd1);
        cdb(5'd1, 32'hA1, 1'b0, 32'd0);
        push_commit(5'd1, 32'hA1, 5'd1);
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = 5'd7;
        tick();
        check("t3_commit_while_full", 64'(bus.commit_valid), 64'd1);
        check("t3_alloc_rejected_full", 64'(bus.rob_full), 64'd0);
        check("t3_alloc_rejected_id", 64'(bus.alloc_id), 64'd1);
        tick();
        bus.alloc_valid = 1'b0;
        check("t3_alloc_wrap_full", 64'(bus.rob_full), 64'd1);
        check("t3_alloc_wrap_id", 64'(bus.alloc_id), 64'd2);

        // Mispredict: commit branch, rollback next cycle, younger entries squashed
        do_reset();
        alloc(5'd0, 1'b1);
        alloc(5'd2, 1'b0);
        alloc(5'd3, 1'b0);
        cdb(5'd2, 32'h22, 1'b0, 32'd0);
        cdb(5'd3, 32'h33, 1'b0, 32'd0);
        push_commit(5'd0, 32'h1, 5'd1);
        exp_q.push_back({1'b1, 5'd0, 32'h100, 5'd0});
        cdb(5'd1, 32'h1, 1'b1, 32'h100);
        check("t4_no_commit_yet", 64'(bus.commit_valid), 64'd0);
        tick();
        check("t4_branch_commit", 64'(bus.commit_valid), 64'd1);
        check("t4_branch_id", 64'(bus.commit_id), 64'd1);
        check("t4_no_rollback_yet", 64'(bus.rollback_signal), 64'd0);
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = 5'd9;
        tick();
        check("t4_rollback", 64'(bus.rollback_signal), 64'd1);
        check("t4_rollback_pc", 64'(bus.rollback_pc), 64'h100);
        check("t4_commit_low", 64'(bus.commit_valid), 64'd0);
        check("t4_alloc_id_reset", 64'(bus.alloc_id), 64'd1);
        tick();
        bus.alloc_valid = 1'b0;
        check("t4_first_alloc_after", 64'(bus.alloc_id), 64'd2);
        check("t4_rollback_pulse_end", 64'(bus.rollback_signal), 64'd0);
        repeat (4) tick();

        // Query, with and without same-cycle CDB forwarding
        do_reset();
        alloc(5'd1, 1'b0);
        alloc(5'd2, 1'b0);
        bus.qry_id    = 5'd2;
        bus.cdb_valid = 1'b1;
        bus.cdb_id    = 5'd2;
        bus.cdb_value = 32'd7;
        #1;
`ifdef ROB_CDB_BYPASS_EN
        check("t5_bypass_ready", 64'(bus.qry_ready), 64'd1);
        check("t5_bypass_value", 64'(bus.qry_value), 64'd7);
`else
        check("t5_nobypass_ready", 64'(bus.qry_ready), 64'd0);
        check("t5_nobypass_value", 64'(bus.qry_value), 64'd0);
`endif
        tick();
        bus.cdb_valid = 1'b0;
        #1;
        check("t5_stored_ready", 64'(bus.qry_ready), 64'd1);
        check("t5_stored_value", 64'(bus.qry_value), 64'd7);
        bus.qry_id = 5'd1;
        #1;
        check("t5_unready_entry", 64'(bus.qry_ready), 64'd0);
        bus.qry_id = 5'd0;
        #1;
        check("t5_id0", 64'(bus.qry_ready), 64'd0);
        push_commit(5'd1, 32'd5, 5'd1);
        push_commit(5'd2, 32'd7, 5'd2);
        cdb(5'd1, 32'd5, 1'b0, 32'd0);
        repeat (4) tick();

        // rdy low holds a ready head back
        do_reset();
        alloc(5'd4, 1'b0);
        push_commit(5'd4, 32'h44, 5'd1);
        cdb(5'd1, 32'h44, 1'b0, 32'd0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_hold_no_commit", 64'(bus.commit_valid), 64'd0);
        end
        rdy = 1'b1;
        tick();
        check("t6_commit_on_rdy", 64'(bus.commit_valid), 64'd1);
        check("t6_commit_value", 64'(bus.commit_value), 64'h44);
        tick();
        check("t6_pulse_end", 64'(bus.commit_valid), 64'd0);

        repeat (3) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
